// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//
// Pipeline hazard controller for a classic 5-stage pipeline. Detects load-use
// hazards, taken branches and data-memory stalls, and drives the PC / pipeline
// register enables, flushes and holds. It also flags a memory access that
// stays pending for too long, and can count the cycles in which the PC is
// stalled.
//
// Optional feature macro: STALL_CNT_EN
//   defined   : StallCount counts the cycles with PCWrite=0 and wraps.
//   undefined : StallCount is tied to 0 and no counter register exists.
//
// Parameters
//   TIMEOUT_CYCLES : MEM_WAIT cycles before MemTimeout is raised (default 255)
//   CNT_W          : width of StallCount (default 32)
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   asynchronous, active-high reset
//   IF_ID_RS/RT    in   [4:0] source registers of the instruction in ID
//   ID_EX_RT       in   [4:0] load destination of the instruction in EX
//   ID_EX_MemRead  in   instruction in EX is a load
//   EX_BranchTaken in   branch/jump resolved taken in EX
//   MEM_Req        in   MEM stage issues a data-memory access
//   MEM_Ready      in   the access completes this cycle
//   PCWrite        out  PC enable
//   IF_ID_Write    out  IF/ID enable
//   IF_ID_Flush    out  bubble into IF/ID
//   ID_EX_Flush    out  bubble into ID/EX
//   MEM_WB_Flush   out  bubble into MEM/WB
//   Pipe_Hold      out  hold ID/EX and EX/MEM
//   MemTimeout     out  sticky memory-timeout flag
//   StallCount     out  [CNT_W-1:0] stall-cycle counter
//
// State table
//   state    | meaning
//   RUN      | normal flow; hazards are detected here
//   LD_STALL | the one bubble cycle after a load-use stall; load-use ignored
//   MEM_WAIT | pipeline frozen while the data-memory access is pending
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_RS,
    input  logic [4:0]       IF_ID_RT,
    input  logic [4:0]       ID_EX_RT,
    input  logic             ID_EX_MemRead,
    input  logic             EX_BranchTaken,
    input  logic             MEM_Req,
    input  logic             MEM_Ready,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             MEM_WB_Flush,
    output logic             Pipe_Hold,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic              load_use;
    logic              mem_stall;

    always_comb begin
        // A load writing r0 never creates a real dependency.
        load_use  = ID_EX_MemRead && (ID_EX_RT != 5'd0) &&
                    ((ID_EX_RT == IF_ID_RS) || (ID_EX_RT == IF_ID_RT));
        // MEM_Req=0 counts as ready, so this also ends MEM_WAIT.
        mem_stall = MEM_Req && !MEM_Ready;

        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Flush   = 1'b0;
        MEM_WB_Flush  = 1'b0;
        Pipe_Hold     = 1'b0;
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;

        case (state_q)
            RUN, LD_STALL: begin
                if (mem_stall) begin
                    // Freeze; any branch or load-use action is deferred and
                    // re-evaluated once the memory access completes.
                    PCWrite      = 1'b0;
                    IF_ID_Write  = 1'b0;
                    Pipe_Hold    = 1'b1;
                    MEM_WB_Flush = 1'b1;
                    wait_cnt_d   = '0;
                    state_d      = MEM_WAIT;
                end else if (EX_BranchTaken) begin
                    PCWrite     = 1'b1;
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                    state_d     = RUN;
                end else if (load_use && (state_q == RUN)) begin
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_EX_Flush = 1'b1;
                    state_d     = LD_STALL;
                end else begin
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_stall) begin
                    PCWrite      = 1'b0;
                    IF_ID_Write  = 1'b0;
                    Pipe_Hold    = 1'b1;
                    MEM_WB_Flush = 1'b1;
                    if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                    if (wait_cnt_d == WAIT_MAX) begin
                        mem_timeout_d = 1'b1;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Reset overrides the inputs so the pipeline sees no stray stall.
        if (reset) begin
            PCWrite      = 1'b1;
            IF_ID_Write  = 1'b1;
            IF_ID_Flush  = 1'b0;
            ID_EX_Flush  = 1'b0;
            MEM_WB_Flush = 1'b0;
            Pipe_Hold    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign MemTimeout = mem_timeout_q;

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!PCWrite) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
`else
    assign StallCount = '0;
`endif

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 The module SHALL have a parameter TIMEOUT_CYCLES, default 255, which sets the number of MEM_WAIT cycles after which MemTimeout is raised.
REQ-002 The module SHALL have a parameter CNT_W, default 32, which sets the width of StallCount.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 The module SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have ports IF_ID_RS and IF_ID_RT, input, 5 bits each: the source registers of the instruction in ID.
REQ-006 The module SHALL have port ID_EX_RT, input, 5 bits: the load destination of the instruction in EX.
REQ-007 The module SHALL have port ID_EX_MemRead, input, 1 bit: the instruction in EX is a load.
REQ-008 The module SHALL have port EX_BranchTaken, input, 1 bit: a branch or jump resolved taken in EX.
REQ-009 The module SHALL have ports MEM_Req, input, 1 bit (the MEM stage issues a data-memory access) and MEM_Ready, input, 1 bit (the access completes this cycle).
REQ-010 The module SHALL have outputs PCWrite and IF_ID_Write, 1 bit each: the PC and IF/ID register enables.
REQ-011 The module SHALL have outputs IF_ID_Flush, ID_EX_Flush and MEM_WB_Flush, 1 bit each: insert a bubble into that register.
REQ-012 The module SHALL have output Pipe_Hold, 1 bit: hold ID/EX and EX/MEM.
REQ-013 The module SHALL have outputs MemTimeout, 1 bit (sticky error flag) and StallCount, CNT_W bits (stall-cycle counter).

Function
REQ-014 LoadUse SHALL be defined as ID_EX_MemRead=1 and ID_EX_RT!=0 and (ID_EX_RT==IF_ID_RS or ID_EX_RT==IF_ID_RT).
REQ-015 MemStall SHALL be defined as MEM_Req=1 and MEM_Ready=0.
REQ-016 The FSM SHALL have exactly three states, RUN, LD_STALL and MEM_WAIT; all control outputs SHALL be combinational from the state and the current inputs.
REQ-017 Priority SHALL be MemStall > EX_BranchTaken > LoadUse.
REQ-018 If MemStall: PCWrite=0, IF_ID_Write=0, Pipe_Hold=1, MEM_WB_Flush=1, IF_ID_Flush=0 and ID_EX_Flush=0, so the branch and load-use actions are deferred; the next state SHALL be MEM_WAIT.
REQ-019 If no MemStall and EX_BranchTaken: PCWrite=1, IF_ID_Flush=1, ID_EX_Flush=1, with LoadUse ignored; the next state SHALL be RUN.
REQ-020 If neither of the above and LoadUse in state RUN: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; the next state SHALL be LD_STALL.
REQ-021 In LD_STALL, LoadUse SHALL be ignored, so the load-use stall is exactly one cycle; absent MemStall, the next state SHALL be RUN.
REQ-022 In MEM_WAIT, the freeze of REQ-018 SHALL hold while MEM_Ready=0; the cycle MEM_Ready=1, all outputs SHALL be at their defaults and the next state SHALL be RUN.
REQ-023 Default outputs SHALL be PCWrite=1, IF_ID_Write=1, and all flush and hold signals 0.
REQ-024 A wait counter SHALL clear on entry to MEM_WAIT and increment in each MEM_WAIT cycle with MEM_Ready=0, saturating at TIMEOUT_CYCLES.
REQ-025 When the wait counter reaches TIMEOUT_CYCLES, MemTimeout SHALL set and remain set until reset; the freeze SHALL continue.
REQ-026 MEM_Req=0 in MEM_WAIT SHALL be treated as MEM_Ready=1.

Reset
REQ-027 While reset=1, the state SHALL be RUN, the wait counter 0, MemTimeout=0 and StallCount=0.
REQ-028 While reset=1, outputs SHALL be PCWrite=1, IF_ID_Write=1, and all flush and hold signals 0, regardless of the other inputs.
REQ-029 Reset asserted in LD_STALL or MEM_WAIT SHALL abort immediately, with no pending stall after release.

Configuration
REQ-030 With STALL_CNT_EN defined, StallCount SHALL increment each cycle PCWrite=0, wrapping from all-ones to 0.
REQ-031 Without STALL_CNT_EN, StallCount SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-032 ID_EX_MemRead=1, ID_EX_RT=8, IF_ID_RS=8 -> one cycle PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; next cycle defaults despite unchanged inputs.
REQ-033 ID_EX_RT=0 with a match on register 0 -> no stall; EX_BranchTaken=1 together with LoadUse -> IF_ID_Flush=ID_EX_Flush=1, PCWrite=1, state stays RUN.
REQ-034 MEM_Req=1, MEM_Ready=0 for 3 cycles then 1 -> Pipe_Hold=1 and MEM_WB_Flush=1 for exactly 3 cycles; StallCount=3 with STALL_CNT_EN.
REQ-035 TIMEOUT_CYCLES=4 and MEM_Ready held 0 -> MemTimeout=1 from the 5th wait cycle and stays 1 after MEM_Ready=1, until reset.
REQ-036 Reset asserted mid-MEM_WAIT -> outputs default immediately; after release with MemStall=0, state is RUN and StallCount=0.
